// File: rtl/ddr2_app_req_packer.sv
// ddr2_app_req_packer
//   Turns one user request (read, or 4-beat write burst carried as two
//   double-width FIFO beats) into DDR2 controller address/write-data FIFO
//   strobes. Requests are accepted only in IDLE; a write spends IDLE->WR0->WR1
//   (3 cycles), a read IDLE->RD (2 cycles).
//   Optional build macro: DDR2_REQ_STATS_EN adds saturating wr_count/rd_count.
//
//   All FIFO-facing outputs are registered. They are computed from the state
//   being entered, so the strobe for a state is visible while the FSM sits in
//   that state (1 cycle after accept for RD/WR0, 2 cycles for WR1).
module ddr2_app_req_packer #(
   parameter int DQ_WIDTH = 32,
   parameter int DM_WIDTH = 4
) (
   input  logic                  clk0,
   input  logic                  rst_n,
   input  logic                  init_done,
   input  logic                  af_almost_full,
   input  logic                  wdf_almost_full,
   input  logic                  usr_valid,
   output logic                  usr_ready,
   input  logic [2:0]            usr_cmd,
   input  logic [31:0]           usr_addr,
   input  logic [4*DQ_WIDTH-1:0] usr_wdata,
   input  logic [4*DM_WIDTH-1:0] usr_mask,
   output logic [35:0]           app_af_addr,
   output logic                  app_af_wren,
   output logic [2*DQ_WIDTH-1:0] app_wdf_data,
   output logic [2*DM_WIDTH-1:0] app_mask_data,
   output logic                  app_wdf_wren,
`ifdef DDR2_REQ_STATS_EN
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count,
`endif
   output logic                  err_illegal
);

   localparam logic [2:0] CMD_WR = 3'b100;
   localparam logic [2:0] CMD_RD = 3'b101;

   typedef enum logic [1:0] {IDLE, WR0, WR1, RD} state_t;

   state_t                  state, state_nx;

   // Beat1 of the accepted write is held until WR1. Command, address and
   // beat0 go straight into the output registers on accept, so no separate
   // copy of them is kept.
   logic [2*DQ_WIDTH-1:0]   beat1_data, beat1_data_nx;
   logic [2*DM_WIDTH-1:0]   beat1_mask, beat1_mask_nx;

   logic                    af_wren_nx;
   logic [35:0]             af_addr_nx;
   logic                    wdf_wren_nx;
   logic [2*DQ_WIDTH-1:0]   wdf_data_nx;
   logic [2*DM_WIDTH-1:0]   mask_data_nx;
   logic                    err_nx;
   logic                    accept;
   logic                    wr_entry;
   logic                    rd_entry;

   // Back-pressure is only looked at while idle; an accepted write always
   // finishes both beats because the FIFOs keep headroom below almost_full.
   assign usr_ready = (state == IDLE) & init_done & ~af_almost_full & ~wdf_almost_full;
   assign accept    = usr_valid & usr_ready;

   // Next-state and next registered FIFO outputs.
   always_comb begin
      state_nx      = state;
      beat1_data_nx = beat1_data;
      beat1_mask_nx = beat1_mask;
      af_wren_nx    = 1'b0;
      af_addr_nx    = '0;
      wdf_wren_nx   = 1'b0;
      wdf_data_nx   = '0;
      mask_data_nx  = '0;
      err_nx        = err_illegal;
      wr_entry      = 1'b0;
      rd_entry      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               beat1_data_nx = usr_wdata[4*DQ_WIDTH-1:2*DQ_WIDTH];
               beat1_mask_nx = usr_mask[4*DM_WIDTH-1:2*DM_WIDTH];
               case (usr_cmd)
                  CMD_WR: begin
                     state_nx     = WR0;
                     wr_entry     = 1'b1;
                     af_wren_nx   = 1'b1;
                     af_addr_nx   = {1'b0, usr_cmd, usr_addr[31:2], 2'b00};
                     wdf_wren_nx  = 1'b1;
                     wdf_data_nx  = usr_wdata[2*DQ_WIDTH-1:0];
                     mask_data_nx = usr_mask[2*DM_WIDTH-1:0];
                  end
                  CMD_RD: begin
                     state_nx   = RD;
                     rd_entry   = 1'b1;
                     af_wren_nx = 1'b1;
                     af_addr_nx = {1'b0, usr_cmd, usr_addr[31:2], 2'b00};
                  end
                  default: err_nx = 1'b1;
               endcase
            end
         end
         WR0: begin
            state_nx     = WR1;
            wdf_wren_nx  = 1'b1;
            wdf_data_nx  = beat1_data;
            mask_data_nx = beat1_mask;
         end
         WR1:     state_nx = IDLE;
         RD:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, held beat1 and registered FIFO outputs; reset abandons any burst.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat1_data    <= '0;
         beat1_mask    <= '0;
         app_af_wren   <= 1'b0;
         app_af_addr   <= '0;
         app_wdf_wren  <= 1'b0;
         app_wdf_data  <= '0;
         app_mask_data <= '0;
         err_illegal   <= 1'b0;
      end else begin
         state         <= state_nx;
         beat1_data    <= beat1_data_nx;
         beat1_mask    <= beat1_mask_nx;
         app_af_wren   <= af_wren_nx;
         app_af_addr   <= af_addr_nx;
         app_wdf_wren  <= wdf_wren_nx;
         app_wdf_data  <= wdf_data_nx;
         app_mask_data <= mask_data_nx;
         err_illegal   <= err_nx;
      end
   end

`ifdef DDR2_REQ_STATS_EN
   // Saturating counts of write and read bursts started.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (wr_entry && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
         if (rd_entry && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule
